// File: rtl/gpu_pkg_p.sv
// Shared GPU types and VRAM geometry for the write-side buffer and its producers.
// The VRAM macros normally come from parameters.vh; the defaults below apply when it is not included first.
`ifndef VRAM_ADDR_WIDTH
`define VRAM_ADDR_WIDTH 12
`endif
`ifndef VRAM_SIZE
`define VRAM_SIZE 12'h900
`endif

package gpu_pkg_p;

  localparam int VRAM_ADDR_W = `VRAM_ADDR_WIDTH;
  localparam logic [VRAM_ADDR_W-1:0] VRAM_LIMIT = `VRAM_SIZE;

  typedef struct packed {
    logic [VRAM_ADDR_W-1:0] address;
    logic [7:0]             data;
  } vram_write_t;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_FILLING = 2'd1,
    ST_FULL    = 2'd2
  } buf_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sync_fifo_m.sv
// Single-clock FIFO with explicit occupancy tracking; the caller guarantees
// no push when full and no pop when empty. clear takes priority over push/pop.
module sync_fifo_m #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clear,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: level gates every use of the contents.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign level = level_q;

endmodule

// File: rtl/vram_write_buffer_m.sv
// Buffers producer VRAM writes and commits them only inside the GPU write window,
// screening out-of-range addresses and keeping overflow/drop statistics.
module vram_write_buffer_m
  import gpu_pkg_p::*;
#(
  parameter int                DEPTH      = 16,
  parameter int                ADDR_W     = VRAM_ADDR_W,
  parameter logic [ADDR_W-1:0] VRAM_LIMIT = ADDR_W'(gpu_pkg_p::VRAM_LIMIT)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [ADDR_W-1:0]      in_address,
  input  logic [7:0]             in_data,
  output logic                   in_ready,
  input  logic                   flush,
  input  logic                   write_window,
  output logic [ADDR_W-1:0]      vram_address,
  output logic [7:0]             vram_data,
  output logic                   vram_write_enable,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic [7:0]             dropped_count
);

  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  // Handshake: a request transfers on any edge where in_valid && in_ready.
  // in_ready never looks at a same-cycle pop, so a full buffer refuses even while draining.

  logic [LVL_W-1:0]  fifo_level;
  logic [LVL_W-1:0]  lvl_next;
  logic [ADDR_W+7:0] fifo_rdata;
  logic              accept, in_range, push, pop;
  buf_state_e        state_q, state_d;
  logic              overflow_q, overflow_d;
  logic [7:0]        dropped_q, dropped_d;

  assign in_ready          = (state_q != ST_FULL) && !flush;
  assign vram_write_enable = write_window && (state_q != ST_EMPTY) && !flush && !rst;
  assign accept            = in_valid && in_ready;
  assign in_range          = in_address < VRAM_LIMIT;
  assign push              = accept && in_range;
  assign pop               = vram_write_enable;

  sync_fifo_m #(
    .WIDTH (ADDR_W + 8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clear (flush),
    .wdata ({in_address, in_data}),
    .rdata (fifo_rdata),
    .level (fifo_level)
  );

  always_comb begin
    lvl_next = fifo_level;
    if (flush) begin
      lvl_next = '0;
    end else begin
      case ({push, pop})
        2'b10:   lvl_next = fifo_level + LVL_W'(1);
        2'b01:   lvl_next = fifo_level - LVL_W'(1);
        default: lvl_next = fifo_level;
      endcase
    end

    if (lvl_next == '0)           state_d = ST_EMPTY;
    else if (lvl_next == FULL_LVL) state_d = ST_FULL;
    else                           state_d = ST_FILLING;

    overflow_d = overflow_q || (in_valid && !in_ready && !flush);
    dropped_d  = (accept && !in_range) ? sat_inc8(dropped_q) : dropped_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      overflow_q <= 1'b0;
      dropped_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      overflow_q <= overflow_d;
      dropped_q  <= dropped_d;
    end
  end

  assign vram_address  = (state_q != ST_EMPTY) ? fifo_rdata[ADDR_W+7:8] : '0;
  assign vram_data     = (state_q != ST_EMPTY) ? fifo_rdata[7:0] : 8'h00;
  assign level         = fifo_level;
  assign overflow      = overflow_q;
  assign dropped_count = dropped_q;

endmodule

// File: doc/vram_write_buffer_m.md
Name: vram_write_buffer_m

Overview:
- Write-side buffer between any VRAM write producer (the VRAM fill sequencer, a CPU bridge) and the GPU VRAM write port.
- Captures address/data write requests into a small FIFO.
- Commits them to VRAM only while the GPU asserts its write window, so producers never collide with pixel fetch.
- Screens out-of-range addresses and reports overflow and drop statistics.

Parameters:
- DEPTH, 16, FIFO entries; power of two, ≥ 2.
- ADDR_W, `VRAM_ADDR_WIDTH (12), VRAM address width.
- VRAM_LIMIT, `VRAM_SIZE (12'h900), first invalid VRAM address.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  producer write request.
- in_address  in  ADDR_W  request address.
- in_data  in  8  request data.
- in_ready  out  1  buffer can accept this cycle.
- flush  in  1  discard all buffered entries.
- write_window  in  1  GPU grants VRAM write access this cycle.
- vram_address  out  ADDR_W  VRAM write address.
- vram_data  out  8  VRAM write data.
- vram_write_enable  out  1  VRAM write strobe.
- level  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky: request presented while full.
- dropped_count  out  8  saturating count of discarded out-of-range requests.

Behaviour:
- Reset, while rst=1 at a clock edge:
  - level=0; read/write pointers=0; overflow=0; dropped_count=0.
  - in_ready=1 in the cycle after reset.
  - vram_write_enable=0.
  - Reset mid-operation discards all entries with no VRAM write.
- Accept:
  - Handshake occurs when in_valid && in_ready.
  - in_ready = (level != DEPTH) && !flush. It is combinational and does not depend on a same-cycle pop.
- Range check on accepted requests:
  - in_address < VRAM_LIMIT: entry is pushed.
  - in_address >= VRAM_LIMIT: not pushed; dropped_count increments by 1 and saturates at 8'hff.
- Overflow: in_valid && !in_ready && !flush sets overflow. It is cleared only by rst.
- Drain, combinational from the FIFO head:
  - vram_write_enable = write_window && level != 0 && !flush.
  - vram_address and vram_data equal the head entry whenever level != 0; both are 0 when the FIFO is empty.
  - A head entry is popped on the same edge at which vram_write_enable is high.
- Latency: an accepted request is visible at the head no earlier than the next cycle. Minimum in-to-VRAM-write latency is 1 cycle; there is no write-through from in_* to vram_*.
- Ordering: strict FIFO. Duplicate addresses are not coalesced.
- Simultaneous push and pop: level unchanged; pointers both advance.
- Full with a pop in the same cycle: the push is still refused (in_ready=0) and overflow is set if in_valid.
- Pointers wrap modulo DEPTH. level is tracked explicitly, not derived from the pointers.
- flush=1:
  - At the edge: pointers and level return to 0.
  - In that cycle: no push, no pop, vram_write_enable=0.
  - overflow and dropped_count are unaffected.
- State machine (level-qualified):
  - EMPTY: level==0.
  - FILLING: 0<level<DEPTH.
  - FULL: level==DEPTH.
  - Transitions follow the push/pop rules above. FULL→FILLING only via a pop. EMPTY is entered on rst, flush, or the last pop.

Decomposition:
- Shared package gpu_pkg_p:
  - typedef vram_write_t, a packed struct {logic [ADDR_W-1:0] address; logic [7:0] data;}.
  - localparam VRAM_LIMIT, derived from `VRAM_SIZE.
  - Existing `VRAM_ADDR_WIDTH/`VRAM_SIZE stay in parameters.vh.
- Sub-module sync_fifo_m (parameterised width/depth):
  - Ports: push, pop, clear, wdata, rdata, level.
  - Synchronous active-high rst.
  - Storage is flops or a distributed RAM array.
- vram_write_buffer_m owns the range check, handshake, overflow, and counters.

Test Plan:
- Reset, then write 0x123←0xA5 with write_window=0 -> level=1 next cycle, vram_write_enable=0. Raise write_window -> one cycle with vram_write_enable=1, vram_address=0x123, vram_data=0xA5; then level=0.
- Push 16 writes to 0x000..0x00F with write_window=0 -> level=16, in_ready=0. A 17th in_valid sets overflow=1 and level stays 16. Open the window -> 16 consecutive writes in order 0x000..0x00F.
- Streaming with write_window=1, in_valid every cycle for addresses 0x400..0x40F -> level ≤1 throughout, VRAM writes lag inputs by 1 cycle, overflow=0.
- Writes to 0x8FF, 0x900, 0xFFF -> only 0x8FF reaches VRAM; dropped_count=2. Then 300 writes to 0x900 -> dropped_count saturates at 0xFF.
- Buffer 5 entries, assert flush for one cycle with write_window=1 -> no VRAM write that cycle, level=0 after it, in_ready=0 during it.
- Buffer 8 entries, assert rst while write_window=1 -> next cycle level=0, vram_write_enable=0, overflow=0, dropped_count=0.
